// File: rtl/ex_seq_pkg.sv
// Shared types and defaults for the EX-stage multi-cycle sequencer.
package ex_seq_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        MUL     = 2'd0,
        DIV     = 2'd1,
        FPU     = 2'd2,
        ILLEGAL = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One-hot {FPU,DIV,MUL} select for a unit; ILLEGAL selects nothing.
    function automatic logic [2:0] unit_onehot(input unit_e unit);
        logic [2:0] oh;
        oh = 3'b000;
        case (unit)
            MUL:     oh = 3'b001;
            DIV:     oh = 3'b010;
            FPU:     oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/ex_seq_timer.sv
// RUN-state cycle counter: restarts at 0 on clear, counts while enabled and
// flags the cycle in which the last allowed count is reached.
module ex_seq_timer
    import ex_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise advance and saturate at the last value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/ex_seq_ctrl.sv
// EX-stage sequencer for multi-cycle MUL/DIV/FPU operations: accepts one op
// from ID/EX, starts the selected unit, waits for its done, and holds the
// result for the MEM stage while stalling the upstream pipeline.
module ex_seq_ctrl
    import ex_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_unit,
    input  logic [2:0]  issue_op,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    output logic [2:0]  unit_start,
    output logic [2:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [2:0]  unit_ready,
    input  logic [31:0] mul_res,
    input  logic [31:0] div_res,
    input  logic [31:0] fpu_res,
    input  logic        flush,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_res,
    input  logic        wb_ack,
    output logic        pipe_stall,
    output logic [1:0]  err
);

    state_e      state_q;
    unit_e       unit_q;
    logic [4:0]  rd_q;
    logic [2:0]  unit_start_q;
    logic [2:0]  unit_op_q;
    logic [31:0] unit_a_q;
    logic [31:0] unit_b_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_res_q;
    logic [1:0]  err_q;

    logic        accept;
    logic        start_cycle;
    logic        sel_ready;
    logic        timer_expired;
    logic [31:0] sel_result;

    // A new op can enter when idle, or when the held result is being consumed
    // this cycle; flush blocks any acceptance.
    assign issue_ready = !flush &&
                         ((state_q == IDLE) || ((state_q == DONE) && wb_ack));
    assign accept      = issue_valid && issue_ready;
    assign pipe_stall  = (state_q == RUN) || ((state_q == DONE) && !wb_ack);

    // The start pulse marks the first RUN cycle, where done is not trusted.
    assign start_cycle = |unit_start_q;
    assign sel_ready   = |(unit_ready & unit_onehot(unit_q));

    // Route the selected unit's result towards the writeback register.
    always_comb begin
        sel_result = '0;
        case (unit_q)
            MUL:     sel_result = mul_res;
            DIV:     sel_result = div_res;
            FPU:     sel_result = fpu_res;
            default: sel_result = '0;
        endcase
    end

    ex_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != RUN),
        .enable (state_q == RUN),
        .expired(timer_expired)
    );

    // Sequencer FSM with registered unit-side and writeback-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            unit_q       <= MUL;
            rd_q         <= '0;
            unit_start_q <= '0;
            unit_op_q    <= '0;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_res_q     <= '0;
            err_q        <= '0;
        end else begin
            unit_start_q <= '0;

            unique case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (!start_cycle && sel_ready) begin
                        wb_res_q   <= sel_result;
                        wb_rd_q    <= rd_q;
                        wb_valid_q <= 1'b1;
                        state_q    <= DONE;
                    end else if (timer_expired) begin
                        err_q[1] <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                DONE: begin
                    if (flush || wb_ack) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Acceptance overrides the state choice above; it only happens
            // from IDLE or from DONE with the result consumed.
            if (accept) begin
                if (unit_e'(issue_unit) == ILLEGAL) begin
                    err_q[0] <= 1'b1;
                    state_q  <= IDLE;
                end else begin
                    unit_q       <= unit_e'(issue_unit);
                    rd_q         <= issue_rd;
                    unit_op_q    <= issue_op;
                    unit_a_q     <= issue_a;
                    unit_b_q     <= issue_b;
                    unit_start_q <= unit_onehot(unit_e'(issue_unit));
                    state_q      <= RUN;
                end
            end
        end
    end

    assign unit_start = unit_start_q;
    assign unit_op    = unit_op_q;
    assign unit_a     = unit_a_q;
    assign unit_b     = unit_b_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_res     = wb_res_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ex_seq_ctrl.sv
// Directed bench for ex_seq_ctrl: cycle-by-cycle vector table plus
// hand-written reset sequences. Built with a short timeout of 8 cycles.
module tb_ex_seq_ctrl;

    localparam logic [31:0] MULR = 32'd42;
    localparam logic [31:0] DIVR = 32'd3;
    localparam logic [31:0] FPUR = 32'h3F80_0000;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_unit;
    logic [2:0]  issue_op;
    logic [4:0]  issue_rd;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [2:0]  unit_start;
    logic [2:0]  unit_op;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic [2:0]  unit_ready;
    logic [31:0] mul_res;
    logic [31:0] div_res;
    logic [31:0] fpu_res;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic        wb_ack;
    logic        pipe_stall;
    logic [1:0]  err;

    int total;
    int bad;

    typedef struct {
        logic [31:0] iv, iu, op, rd, a, b, ur, fl, ack;
        logic [31:0] eir, eus, ewv, erd, eres, eps, eerr;
    } vec_t;

    vec_t vecs[$];

    ex_seq_ctrl #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_unit (issue_unit),
        .issue_op   (issue_op),
        .issue_rd   (issue_rd),
        .issue_a    (issue_a),
        .issue_b    (issue_b),
        .unit_start (unit_start),
        .unit_op    (unit_op),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_ready (unit_ready),
        .mul_res    (mul_res),
        .div_res    (div_res),
        .fpu_res    (fpu_res),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_res     (wb_res),
        .wb_ack     (wb_ack),
        .pipe_stall (pipe_stall),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [31:0] iv, iu, op, rd, a, b, ur, fl, ack,
        input logic [31:0] eir, eus, ewv, erd, eres, eps, eerr);
        vec_t v;
        v.iv = iv;   v.iu = iu;   v.op = op;   v.rd = rd;   v.a = a;
        v.b = b;     v.ur = ur;   v.fl = fl;   v.ack = ack;
        v.eir = eir; v.eus = eus; v.ewv = ewv; v.erd = erd;
        v.eres = eres; v.eps = eps; v.eerr = eerr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        issue_valid = v.iv[0];
        issue_unit  = v.iu[1:0];
        issue_op    = v.op[2:0];
        issue_rd    = v.rd[4:0];
        issue_a     = v.a;
        issue_b     = v.b;
        unit_ready  = v.ur[2:0];
        flush       = v.fl[0];
        wb_ack      = v.ack[0];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " issue_ready"}, 32'(issue_ready), 32'd1);
        checkOutput({tag, " unit_start"},  32'(unit_start),  32'd0);
        checkOutput({tag, " unit_op"},     32'(unit_op),     32'd0);
        checkOutput({tag, " unit_a"},      unit_a,           32'd0);
        checkOutput({tag, " unit_b"},      unit_b,           32'd0);
        checkOutput({tag, " wb_valid"},    32'(wb_valid),    32'd0);
        checkOutput({tag, " wb_rd"},       32'(wb_rd),       32'd0);
        checkOutput({tag, " wb_res"},      wb_res,           32'd0);
        checkOutput({tag, " err"},         32'(err),         32'd0);
        checkOutput({tag, " pipe_stall"},  32'(pipe_stall),  32'd0);
    endtask

    // Hard stop in case the run never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        mul_res = MULR;
        div_res = DIVR;
        fpu_res = FPUR;

        // MUL a=7 b=6, done two cycles after start; stray done in start cycle
        // and non-selected done bits must be ignored
        vecs.push_back(mk(1,0,3,5,7,6, 0,0,0, 1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0, 0,1,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 6,0,0, 0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0, 0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,0,1,5,MULR,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,0,0, 0,0,1,5,MULR,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,1, 1,0,1,5,MULR,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,0,0,0,0,0,0));
        // DIV held three cycles in DONE, then ack with back-to-back FPU issue
        vecs.push_back(mk(1,1,1,9,100,33, 0,0,0, 1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 2,0,0, 0,2,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 2,0,0, 0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,0,1,9,DIVR,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,0,1,9,DIVR,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,0,1,9,DIVR,1,0));
        vecs.push_back(mk(1,2,5,17,1,2, 0,0,1, 1,0,1,9,DIVR,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,4,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 4,0,0, 0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,0,1,17,FPUR,1,0));
        // flush in DONE together with ack and a new issue
        vecs.push_back(mk(1,0,0,2,0,0, 0,1,1, 0,0,1,17,FPUR,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,0,0,0,0,0,0));
        // DIV flushed in RUN in the same cycle its done arrives
        vecs.push_back(mk(1,1,2,3,50,5, 0,0,0, 1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,2,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,4,0,0, 2,1,0, 0,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,4,0,0, 0,1,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,0,0,0,0,0,0));
        // MUL never completes: abort after exactly 8 RUN cycles
        vecs.push_back(mk(1,0,1,1,3,4, 0,0,0, 1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,1,0,0,0,1,0));
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(0,0,0,0,0,0, 6,0,0, 0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,0,0,0,0,0,2));
        // illegal unit: accepted, no start, sticky illegal flag
        vecs.push_back(mk(1,3,0,6,0,0, 0,0,0, 1,0,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,0,0,0,0,0,3));
        vecs.push_back(mk(0,0,0,0,0,0, 7,0,0, 1,0,0,0,0,0,3));

        repeat (2) @(negedge clk);
        #1 checkResetValues("por");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d issue_ready", i), 32'(issue_ready), vecs[i].eir);
            checkOutput($sformatf("row%0d unit_start", i),  32'(unit_start),  vecs[i].eus);
            checkOutput($sformatf("row%0d wb_valid", i),    32'(wb_valid),    vecs[i].ewv);
            checkOutput($sformatf("row%0d pipe_stall", i),  32'(pipe_stall),  vecs[i].eps);
            checkOutput($sformatf("row%0d err", i),         32'(err),         vecs[i].eerr);
            if (vecs[i].ewv[0]) begin
                checkOutput($sformatf("row%0d wb_rd", i),  32'(wb_rd), vecs[i].erd);
                checkOutput($sformatf("row%0d wb_res", i), wb_res,     vecs[i].eres);
            end
        end

        // Operand latching, then asynchronous reset in the middle of RUN
        @(negedge clk);
        applyStimulus(mk(1,0,6,12,32'hA5A5_0001,32'h5A5A_0002, 0,0,0, 0,0,0,0,0,0,0));
        #1 checkOutput("mr accept ready", 32'(issue_ready), 32'd1);
        @(negedge clk);
        applyStimulus(mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        #1;
        checkOutput("mr start",  32'(unit_start), 32'd1);
        checkOutput("mr op",     32'(unit_op),    32'd6);
        checkOutput("mr a",      unit_a,          32'hA5A5_0001);
        checkOutput("mr b",      unit_b,          32'h5A5A_0002);
        @(negedge clk);
        #1;
        checkOutput("mr start gone", 32'(unit_start), 32'd0);
        checkOutput("mr a held",     unit_a,          32'hA5A5_0001);
        checkOutput("mr stall",      32'(pipe_stall), 32'd1);
        #2;
        rst_n      = 1'b0;
        unit_ready = 3'b001;
        #1 checkResetValues("midrun");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post ready",    32'(issue_ready), 32'd1);
        checkOutput("post wb_valid", 32'(wb_valid),    32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("post%0d wb_valid", k),  32'(wb_valid),   32'd0);
            checkOutput($sformatf("post%0d start", k),     32'(unit_start), 32'd0);
            checkOutput($sformatf("post%0d stall", k),     32'(pipe_stall), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_seq_ctrl.md
EX_SEQ_CTRL -- requirements
Module: ex_seq_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, maximum RUN cycles before abort.
REQ-002 Port: clk  in  1  system clock, all state on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: issue_valid  in  1  ID/EX offers a multi-cycle op.
REQ-005 Port: issue_ready  out  1  op accepted this cycle when issue_valid is also high.
REQ-006 Port: issue_unit  in  2  target unit: 0 MUL, 1 DIV, 2 FPU, 3 illegal.
REQ-007 Port: issue_op  in  3  sub-op (mulsel/divsel/fpusel code).
REQ-008 Port: issue_rd  in  5  destination register.
REQ-009 Port: issue_a, issue_b  in  32 each  forwarded operands.
REQ-010 Port: unit_start  out  3  one-hot start pulse {FPU,DIV,MUL}.
REQ-011 Port: unit_op  out  3  latched sub-op, held for the whole operation.
REQ-012 Port: unit_a, unit_b  out  32 each  latched operands, held for the whole operation.
REQ-013 Port: unit_ready  in  3  per-unit done {FPU,DIV,MUL}.
REQ-014 Port: mul_res, div_res, fpu_res  in  32 each  unit results.
REQ-015 Port: flush  in  1  kill in-flight op.
REQ-016 Port: wb_valid  out  1  result available.
REQ-017 Port: wb_rd  out  5  destination of result.
REQ-018 Port: wb_res  out  32  result.
REQ-019 Port: wb_ack  in  1  MEM stage consumed the result.
REQ-020 Port: pipe_stall  out  1  freeze upstream pipeline registers.
REQ-021 Port: err  out  2  sticky flags {timeout, illegal}.

Function
REQ-022 FSM states SHALL be IDLE, RUN, DONE.
REQ-023 issue_ready SHALL equal (state==IDLE) or (state==DONE and wb_ack), and SHALL be gated low by flush.
REQ-024 Accept in cycle N (legal unit): latch op/rd/a/b/unit, enter RUN; unit_start bit SHALL pulse in cycle N+1 only.
REQ-025 unit_ready SHALL be ignored in the start cycle and for non-selected units.
REQ-026 Selected unit_ready high in a RUN cycle: capture that unit's result into wb_res; enter DONE next cycle with wb_valid=1.
REQ-027 Minimum latency SHALL be 3 cycles from accept to wb_valid; each extra unit cycle SHALL add one.
REQ-028 In DONE, wb_valid/wb_rd/wb_res SHALL hold stable until wb_ack; wb_ack returns to IDLE, or to RUN if a new op is accepted in the same cycle.
REQ-029 pipe_stall SHALL be (state==RUN) or (state==DONE and not wb_ack).
REQ-030 flush in RUN or DONE: next state IDLE; wb_valid low; late unit_ready discarded; no error flagged.
REQ-031 flush SHALL win over simultaneous unit_ready, wb_ack and issue_valid.
REQ-032 RUN counter SHALL start at 0 on entry and increment each RUN cycle; reaching TIMEOUT_CYCLES-1 without ready: set err[1], go IDLE, no writeback.
REQ-033 issue_unit==3: accept (issue_ready high), no start pulse, set err[0], remain IDLE.
REQ-034 err bits SHALL clear only on reset.

Reset
REQ-035 On rst_n low: state IDLE, unit_start 0, unit_op 0, unit_a/unit_b 0, wb_valid 0, wb_rd 0, wb_res 0, err 0, counter 0, pipe_stall 0.
REQ-036 Reset mid-operation SHALL abandon the op without start or writeback; issue_ready SHALL be 1 in the first cycle after release.

Structure
REQ-037 Shared package ex_seq_pkg SHALL hold the unit_e enum (MUL/DIV/FPU/ILLEGAL), the state_e enum and the TIMEOUT_CYCLES default.
REQ-038 The RUN cycle counter with its timeout compare SHALL be a sub-module ex_seq_timer (clear, enable, expired).

Verification
REQ-039 MUL a=7 b=6, MUL ready 2 cycles after start -> wb_valid 4 cycles after accept, wb_res=mul_res=42, wb_rd held until wb_ack.
REQ-040 DIV accepted, wb_ack low 3 cycles in DONE -> pipe_stall high throughout; outputs stable; single writeback.
REQ-041 DONE with wb_ack and a new FPU issue in the same cycle -> accept; FPU start pulses next cycle; no IDLE bubble.
REQ-042 DIV in RUN, flush and div ready in the same cycle -> IDLE, no wb_valid, err=0.
REQ-043 TIMEOUT_CYCLES=8, MUL ready never asserted -> err=2'b10 after 8 RUN cycles; then idle with issue_ready=1.
REQ-044 issue_unit=3 -> unit_start=0, err[0]=1; rst_n pulse asserted mid-RUN -> all outputs at reset values.
